// File: rtl/rv_pkg.sv
// Shared RV32I constants and types for the execute/control slice.
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IMM_I   = 2'b00,
    IMM_S   = 2'b01,
    IMM_B   = 2'b10,
    IMM_UNU = 2'b11
  } imm_src_e;

  // funct3 -> ALU operation; sltu (011) is unsupported and falls back to add.
  function automatic alu_ctrl_e alu_from_funct3(input logic [2:0] funct3,
                                                input logic       sub_sel);
    alu_ctrl_e op;
    op = ALU_ADD;
    case (funct3)
      3'b000:  op = sub_sel ? ALU_SUB : ALU_ADD;
      3'b111:  op = ALU_AND;
      3'b110:  op = ALU_OR;
      3'b100:  op = ALU_XOR;
      3'b010:  op = ALU_SLT;
      3'b001:  op = ALU_SLL;
      3'b101:  op = ALU_SRL;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_alu.sv
// RV32I ALU: add/sub/and/or/xor/slt/sll/srl with zero flag.
module rv_alu
  import rv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] src_a_i,
  input  logic [DATA_WIDTH-1:0] src_b_i,
  input  alu_ctrl_e             alu_ctrl_i,
  output logic [DATA_WIDTH-1:0] alu_out_o,
  output logic                  zero_o
);

  localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);

  logic [SHAMT_W-1:0] shamt;
  logic               slt_bit;

  assign shamt   = src_b_i[SHAMT_W-1:0];
  assign slt_bit = $signed(src_a_i) < $signed(src_b_i);

  always_comb begin
    alu_out_o = src_a_i + src_b_i;
    case (alu_ctrl_i)
      ALU_ADD: alu_out_o = src_a_i + src_b_i;
      ALU_SUB: alu_out_o = src_a_i - src_b_i;
      ALU_AND: alu_out_o = src_a_i & src_b_i;
      ALU_OR:  alu_out_o = src_a_i | src_b_i;
      ALU_XOR: alu_out_o = src_a_i ^ src_b_i;
      ALU_SLT: alu_out_o = DATA_WIDTH'(slt_bit);
      ALU_SLL: alu_out_o = src_a_i << shamt;
      ALU_SRL: alu_out_o = src_a_i >> shamt;
      default: alu_out_o = src_a_i + src_b_i;
    endcase
  end

  assign zero_o = (alu_out_o == '0);

endmodule

// File: rtl/rv_exec_ctrl.sv
// Single-cycle RV32I execute/control slice: PC register, PC adders,
// next-PC select, main/ALU decoder and ALU.
module rv_exec_ctrl
  import rv_pkg::*;
#(
  parameter int unsigned         DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instruction,
  input  logic [DATA_WIDTH-1:0] rd1,
  input  logic [DATA_WIDTH-1:0] rd2,
  input  logic [DATA_WIDTH-1:0] imm_op,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] inc_pc,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic                  zero,
  output logic                  reg_wr_en,
  output logic                  mem_wr_en,
  output logic                  result_src,
  output logic [1:0]            imm_src,
  output logic                  pc_src
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       unused_instr;

  assign opcode       = instruction[6:0];
  assign funct3       = instruction[14:12];
  assign funct7_5     = instruction[30];
  assign unused_instr = ^{instruction[31], instruction[29:15], instruction[11:7]};

  logic [DATA_WIDTH-1:0] pc_d, pc_q;
  logic [DATA_WIDTH-1:0] branch_pc;
  logic [DATA_WIDTH-1:0] src_b;
  logic                  alu_src;
  logic                  is_beq, is_bne;
  alu_ctrl_e             alu_ctrl;
  imm_src_e              imm_sel;

  // Main decoder; branch resolution is kept out of here so zero does not loop back.
  always_comb begin
    reg_wr_en  = 1'b0;
    mem_wr_en  = 1'b0;
    result_src = 1'b0;
    alu_src    = 1'b0;
    imm_sel    = IMM_I;
    alu_ctrl   = ALU_ADD;
    is_beq     = 1'b0;
    is_bne     = 1'b0;
    case (opcode)
      OP_LOAD: begin
        reg_wr_en  = 1'b1;
        alu_src    = 1'b1;
        result_src = 1'b1;
      end
      OP_STORE: begin
        mem_wr_en = 1'b1;
        alu_src   = 1'b1;
        imm_sel   = IMM_S;
      end
      OP_RTYPE: begin
        reg_wr_en = 1'b1;
        alu_ctrl  = alu_from_funct3(funct3, funct7_5);
      end
      OP_IMM: begin
        reg_wr_en = 1'b1;
        alu_src   = 1'b1;
        alu_ctrl  = alu_from_funct3(funct3, 1'b0);
      end
      OP_BRANCH: begin
        imm_sel  = IMM_B;
        alu_ctrl = ALU_SUB;
        is_beq   = (funct3 == F3_BEQ);
        is_bne   = (funct3 == F3_BNE);
      end
      default: ;
    endcase
  end

  assign imm_src = imm_sel;
  assign src_b   = alu_src ? imm_op : rd2;

  rv_alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .src_a_i    (rd1),
    .src_b_i    (src_b),
    .alu_ctrl_i (alu_ctrl),
    .alu_out_o  (alu_out),
    .zero_o     (zero)
  );

  assign pc_src    = (is_beq & zero) | (is_bne & ~zero);
  assign inc_pc    = pc_q + DATA_WIDTH'(4);
  assign branch_pc = pc_q + imm_op;
  assign pc_d      = pc_src ? branch_pc : inc_pc;

  // PC register; reset wins over any branch on the same edge.
  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_rv_exec_ctrl.sv
// Self-checking bench for rv_exec_ctrl: directed cases plus random instructions
// compared against a behavioural RV32I subset model.
module tb_rv_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction, rd1, rd2, imm_op;
  logic [31:0] pc, inc_pc, alu_out;
  logic        zero, reg_wr_en, mem_wr_en, result_src, pc_src;
  logic [1:0]  imm_src;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc;
  logic [31:0] exp_next;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] SUB   = 32'h4020_8033;
  localparam logic [31:0] ADD   = 32'h0020_8033;
  localparam logic [31:0] ADDI7 = 32'h4000_0013;
  localparam logic [31:0] SLT   = 32'h0000_2033;
  localparam logic [31:0] LW    = 32'h0000_2003;
  localparam logic [31:0] SW    = 32'h0000_2023;
  localparam logic [31:0] BEQ   = 32'h0000_0063;
  localparam logic [31:0] BNE   = 32'h0000_1063;

  always #5 clk = ~clk;

  rv_exec_ctrl #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .rd1         (rd1),
    .rd2         (rd2),
    .imm_op      (imm_op),
    .pc          (pc),
    .inc_pc      (inc_pc),
    .alu_out     (alu_out),
    .zero        (zero),
    .reg_wr_en   (reg_wr_en),
    .mem_wr_en   (mem_wr_en),
    .result_src  (result_src),
    .imm_src     (imm_src),
    .pc_src      (pc_src)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one instruction, compare every combinational output with the model.
  task automatic apply(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic r);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] opb, res;
    logic        is_ld, is_st, is_r, is_i, is_br, take;
    logic [1:0]  e_imm;
    instruction = ins; rd1 = a; rd2 = b; imm_op = im; rst = r;
    #1;
    op = ins[6:0];
    f3 = ins[14:12];
    is_ld = (op == 7'b0000011);
    is_st = (op == 7'b0100011);
    is_r  = (op == 7'b0110011);
    is_i  = (op == 7'b0010011);
    is_br = (op == 7'b1100011);
    opb   = (is_ld || is_st || is_i) ? im : b;
    res   = a + opb;
    if (is_br) res = a - opb;
    else if (is_r || is_i) begin
      if (f3 == 3'd0 && is_r && ins[30]) res = a - opb;
      else if (f3 == 3'd7) res = a & opb;
      else if (f3 == 3'd6) res = a | opb;
      else if (f3 == 3'd4) res = a ^ opb;
      else if (f3 == 3'd2) res = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
      else if (f3 == 3'd1) res = a << opb[4:0];
      else if (f3 == 3'd5) res = a >> opb[4:0];
    end
    take  = is_br && ((f3 == 3'd0 && a == b) || (f3 == 3'd1 && a != b));
    e_imm = is_st ? 2'b01 : (is_br ? 2'b10 : 2'b00);
    check("pc", pc, m_pc);
    check("inc_pc", inc_pc, m_pc + 32'd4);
    check("alu_out", alu_out, res);
    check("zero", 32'(zero), 32'(res == 32'd0));
    check("reg_wr_en", 32'(reg_wr_en), 32'(is_ld || is_r || is_i));
    check("mem_wr_en", 32'(mem_wr_en), 32'(is_st));
    check("result_src", 32'(result_src), 32'(is_ld));
    check("imm_src", 32'(imm_src), 32'(e_imm));
    check("pc_src", 32'(pc_src), 32'(take));
    exp_next = r ? 32'd0 : (take ? m_pc + im : m_pc + 32'd4);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    m_pc = exp_next;
    check("pc_next", pc, m_pc);
  endtask

  initial begin
    logic [31:0] ins, a, b, im;
    logic [6:0]  ops [7];
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
    ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b0000000; ops[6] = 7'b1101111;

    rst = 1'b1; instruction = NOP; rd1 = '0; rd2 = '0; imm_op = '0;
    @(posedge clk); #1;
    m_pc = 32'd0;
    check("reset_pc", pc, 32'd0);

    // Advance to a nonzero PC, then reset for two cycles.
    apply(NOP, 0, 0, 0, 1'b0); step();
    apply(NOP, 0, 0, 0, 1'b0); step();
    check("pc_before_rst", pc, 32'd8);
    apply(NOP, 0, 0, 0, 1'b1); step();
    check("pc_rst1", pc, 32'd0);
    apply(NOP, 0, 0, 0, 1'b1); step();
    check("pc_rst2", pc, 32'd0);
    apply(NOP, 0, 0, 0, 1'b0);
    check("nop_wr", 32'({reg_wr_en, mem_wr_en, result_src, pc_src}), 32'd0);
    step(); check("pc_4", pc, 32'd4);
    apply(NOP, 0, 0, 0, 1'b0); step(); check("pc_8", pc, 32'd8);

    apply(SUB, 32'd10, 32'd3, 32'd0, 1'b0);
    check("sub_out", alu_out, 32'd7); check("sub_wr", 32'(reg_wr_en), 32'd1);
    check("sub_zero", 32'(zero), 32'd0); step();
    apply(ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    check("add_out", alu_out, 32'd0); check("add_zero", 32'(zero), 32'd1); step();
    apply(ADDI7, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    check("addi_out", alu_out, 32'd4); step();
    apply(SLT, 32'hFFFF_FFFE, 32'd1, 32'd0, 1'b0);
    check("slt_out", alu_out, 32'd1); step();
    apply(LW, 32'h100, 32'd0, 32'd8, 1'b0);
    check("lw_out", alu_out, 32'h108); check("lw_rs", 32'(result_src), 32'd1);
    check("lw_imm", 32'(imm_src), 32'd0); step();
    apply(SW, 32'h100, 32'd5, 32'd4, 1'b0);
    check("sw_mem", 32'(mem_wr_en), 32'd1); check("sw_wr", 32'(reg_wr_en), 32'd0);
    check("sw_imm", 32'(imm_src), 32'd1); step();

    // Branches around pc 0x20.
    apply(BEQ, 32'd1, 32'd1, 32'h20 - m_pc, 1'b0); step();
    check("pc_20", pc, 32'h20);
    apply(BEQ, 32'd7, 32'd7, 32'hFFFF_FFF8, 1'b0);
    check("beq_take", 32'(pc_src), 32'd1); step();
    check("beq_pc", pc, 32'h18);
    apply(BEQ, 32'd2, 32'd2, 32'd8, 1'b0); step();
    apply(BNE, 32'd7, 32'd7, 32'hFFFF_FFF8, 1'b0);
    check("bne_take", 32'(pc_src), 32'd0); step();
    check("bne_pc", pc, 32'h24);

    // PC wrap, then reset beating a taken branch.
    apply(BEQ, 32'd0, 32'd0, 32'hFFFF_FFFC - m_pc, 1'b0); step();
    check("pc_top", pc, 32'hFFFF_FFFC);
    apply(NOP, 0, 0, 0, 1'b0);
    check("inc_wrap", inc_pc, 32'd0); step();
    check("pc_wrap", pc, 32'd0);
    apply(BEQ, 32'd3, 32'd3, 32'h40, 1'b1);
    check("rst_br_take", 32'(pc_src), 32'd1); step();
    check("rst_prio", pc, 32'd0);

    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 6)];
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      im = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) - 32'd32 : $urandom;
      apply(ins, a, b, im, ($urandom_range(0, 31) == 0));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv_exec_ctrl.md
Name: rv_exec_ctrl

Overview:
- Single-cycle RV32I execute/control slice containing:
  - the PC register
  - the PC+4 and PC+imm adders
  - the next-PC select
  - the main/ALU decoder (control unit)
  - the ALU with its operand-B select
- Sits between instruction memory / sign extender / register file (inputs) and data memory / register-file write-back (outputs).
- All logic except the PC register is combinational.

Parameters:
- DATA_WIDTH, 32, datapath width; only 32 is required to work.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- instruction  input  32  current instruction (fields: opcode[6:0], funct3[14:12], funct7_5 = bit 30)
- rd1  input  DATA_WIDTH  register-file read data for rs1
- rd2  input  DATA_WIDTH  register-file read data for rs2
- imm_op  input  DATA_WIDTH  sign-extended immediate (already shifted/formatted by extender)
- pc  output  DATA_WIDTH  current PC (registered)
- inc_pc  output  DATA_WIDTH  pc + 4
- alu_out  output  DATA_WIDTH  ALU result (also data-memory address)
- zero  output  1  alu_out == 0
- reg_wr_en  output  1  register-file write enable
- mem_wr_en  output  1  data-memory write enable
- result_src  output  1  0 = ALU result, 1 = memory read data
- imm_src  output  2  00 I-type, 01 S-type, 10 B-type, 11 unused
- pc_src  output  1  1 = take branch

Behaviour:
- PC register:
  - On posedge clk: if rst, pc <= RESET_PC; else pc <= next_pc.
  - Reset overrides everything.
  - Reset asserted mid-program takes effect at that edge; the next instruction fetched is RESET_PC.
- Adders and next PC:
  - inc_pc = pc + 4.
  - branch_pc = pc + imm_op.
  - next_pc = pc_src ? branch_pc : inc_pc.
  - Both adders are modulo 2^32; wrap silently, no carry out.
- Decode by opcode:
  - 0000011 lw: reg_wr_en=1, imm_src=00, alu_src=1, result_src=1, ALU add.
  - 0100011 sw: mem_wr_en=1, imm_src=01, alu_src=1, ALU add.
  - 0110011 R-type: reg_wr_en=1, alu_src=0, ALU op from funct3/funct7_5.
  - 0010011 I-ALU: reg_wr_en=1, imm_src=00, alu_src=1, ALU op from funct3.
  - 1100011 branch: imm_src=10, alu_src=0, ALU sub.
    - funct3 000 (beq): pc_src = zero.
    - funct3 001 (bne): pc_src = !zero.
    - Other funct3: pc_src = 0.
  - Any other opcode: reg_wr_en, mem_wr_en, result_src, pc_src all 0; imm_src=00; ALU add.
- ALU decode (funct3 for R/I types), with 3-bit alu_control:
  - 000 → sub (001) only if R-type and funct7_5=1; otherwise add (000).
  - 111 → and (010).
  - 110 → or (011).
  - 100 → xor (100).
  - 010 → slt (101).
  - 001 → sll (110).
  - 101 → srl (111).
  - 011 (sltu) is unsupported: decodes to add; reg_wr_en stays as per opcode.
- ALU:
  - Operand A = rd1; operand B = alu_src ? imm_op : rd2.
  - add/sub: modulo 2^32.
  - slt: signed compare, result 1 or 0 zero-extended.
  - sll/srl: shift by B[4:0]; srl is logical.
  - zero = (alu_out == 0) for every operation.
- All outputs except pc are purely combinational from inputs and pc. No internal state besides pc.

Decomposition:
- Shared package rv_pkg:
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_IMM, OP_BRANCH)
  - alu_control enum (ALU_ADD..ALU_SRL, 3 bits)
  - imm_src enum
  - RESET_PC default
- Natural sub-modules:
  - rv_alu: operands, alu_control → alu_out, zero.
  - Decoder as an always_comb block inside the top.
  - Adders inline.

Test Plan:
- Reset: hold rst=1 two cycles with pc nonzero → pc=0 after first edge; release → pc 0→4→8 with NOP-class (unknown opcode 0000000) instructions, all enables 0.
- R-type: instruction 0x40208033 (sub x0,x1,x2), rd1=10, rd2=3 → alu_out=7, reg_wr_en=1, zero=0; add (0x00208033) with rd1=0xFFFFFFFF, rd2=1 → alu_out=0, zero=1.
- I-ALU: addi with funct7-position bit 30=1, rd1=5, imm_op=0xFFFFFFFF → add (not sub), alu_out=4; slt with rd1=0xFFFFFFFE, rd2=1 → alu_out=1.
- Load/store: lw with rd1=0x100, imm_op=8 → alu_out=0x108, result_src=1, reg_wr_en=1, imm_src=00; sw → mem_wr_en=1, reg_wr_en=0, imm_src=01.
- Branches at pc=0x20, imm_op=0xFFFFFFF8:
  - beq, rd1=rd2 → pc_src=1, next pc=0x18.
  - bne with equal operands → pc_src=0, next pc=0x24.
- Wrap and reset priority: pc=0xFFFFFFFC → inc_pc=0 (next pc=0); branch taken with rst=1 same edge → pc=0.
